// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0040;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        predict_taken;
        logic [31:0] predict_target;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // A taken branch whose target differs from the prediction is a mispredict
    // even when the direction matched.
    function automatic logic is_mispredict(
        input logic        branch_taken,
        input logic [31:0] jump_target,
        input logic        predict_taken,
        input logic [31:0] predict_target
    );
        return (branch_taken != predict_taken) ||
               (branch_taken && (jump_target != predict_target));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Pointer/count FIFO with synchronous clear and a combinational head read.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_pop;

    assign do_pop     = pop && (count_reg != '0);
    assign head       = mem[rd_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC/prediction, one in-flight imem read,
// and a decoupling queue toward decode, flushed on MB-stage redirects.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_read,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pred_pc,
    input  logic               pred_taken,
    input  logic [31:0]        pred_target,
    input  logic               mb_if__valid,
    input  logic               mb_if__branch_taken,
    input  logic               mb_if__trap_taken,
    input  logic [31:0]        mb_if__jump_target,
    input  logic               mb_if__predict_taken,
    input  logic [31:0]        mb_if__predict_target,
    input  logic [31:0]        mb_if__pc_4,
    input  logic               id_ready,
    output logic               if_id__valid,
    output logic [31:0]        if_id__pc,
    output logic [31:0]        if_id__ins,
    output logic               if_id__predict_taken,
    output logic [31:0]        if_id__predict_target,
    output logic               if_id__instret,
    output logic               pipe_flush
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]  pc_reg;
    logic         pipe_flush_reg;
    logic         inflight_reg;
    logic [31:0]  inflight_pc_reg;
    logic         inflight_pt_reg;
    logic [31:0]  inflight_ptgt_reg;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic [PW:0]  count;
    logic [PW+1:0] occupancy;
    logic         enq;
    logic         deq;
    fetch_entry_t enq_entry;
    fetch_entry_t head_entry;
    logic         head_valid;

    // The cycle right after a redirect ignores the MB stage, since whatever it
    // reports belongs to the squashed path.
    assign redirect = mb_if__valid && !pipe_flush_reg &&
                      (mb_if__trap_taken ||
                       is_mispredict(mb_if__branch_taken, mb_if__jump_target,
                                     mb_if__predict_taken, mb_if__predict_target));
    assign redirect_target = (mb_if__trap_taken || mb_if__branch_taken) ?
                             mb_if__jump_target : mb_if__pc_4;

    // Credit counts the outstanding read so a full queue never overflows.
    assign occupancy = {1'b0, count} + (PW+2)'(inflight_reg);
    assign imem_read = !redirect && (occupancy < (PW+2)'(DEPTH));
    assign imem_addr = pc_reg[IMEM_AW+1:2];
    assign pred_pc   = pc_reg;

    assign enq = inflight_reg && !redirect;
    assign deq = head_valid && id_ready;

    always_comb begin
        enq_entry                = '0;
        enq_entry.pc             = inflight_pc_reg;
        enq_entry.ins            = imem_data;
        enq_entry.predict_taken  = inflight_pt_reg;
        enq_entry.predict_target = inflight_ptgt_reg;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect),
        .push       (enq),
        .pop        (deq),
        .din        (enq_entry),
        .head       (head_entry),
        .head_valid (head_valid),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg            <= RESET_PC;
            pipe_flush_reg    <= 1'b1;
            inflight_reg      <= 1'b0;
            inflight_pc_reg   <= '0;
            inflight_pt_reg   <= 1'b0;
            inflight_ptgt_reg <= '0;
        end else begin
            pipe_flush_reg <= redirect;
            inflight_reg   <= imem_read;
            if (redirect) begin
                pc_reg <= redirect_target;
            end else if (imem_read) begin
                pc_reg            <= pred_taken ? pred_target : pc_reg + 32'd4;
                inflight_pc_reg   <= pc_reg;
                inflight_pt_reg   <= pred_taken;
                inflight_ptgt_reg <= pred_target;
            end
        end
    end

    assign pipe_flush            = pipe_flush_reg;
    assign if_id__valid          = head_valid;
    assign if_id__pc             = head_entry.pc;
    assign if_id__ins            = head_entry.ins;
    assign if_id__predict_taken  = head_entry.predict_taken;
    assign if_id__predict_target = head_entry.predict_target;
    assign if_id__instret        = head_valid && id_ready;

endmodule
